// File: rtl/ifu_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue_pkg
//   Shared configuration and types for the instruction fetch queue.
//   FQ_DEPTH  : default number of queue entries (power of two, >= 2).
//   BP_ADDR_W : width of the BPU entry index carried with each instruction.
//   fq_entry_t: one queue entry (request metadata plus the returned word).
// ---------------------------------------------------------------------------
package ifu_fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned BP_ADDR_W = 4;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pc_plus;
    logic                 bp_taken;
    logic                 bp_match;
    logic [BP_ADDR_W-1:0] bp_addr;
    logic [31:0]          bp_pc;
    logic [31:0]          inst;
  } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue
//   Sits between the fetch/imem interface and decode. Metadata is captured
//   when a fetch request is handshaked, paired with the in-order imem
//   response, and the complete instruction is handed to decode. A flush
//   squashes every queued entry and remembers how many responses are still
//   owed to squashed requests so they can be discarded when they arrive.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   if_valid, if_*      request handshake and its metadata (allocates entry)
//   imem_resp_valid/data in-order instruction response
//   fq_flush            squash all queued and in-flight fetches
//   fq_full             registered; fetch must not handshake while high
//   id_valid/id_ready   decode handshake for the head entry
//   id_*                head metadata, instruction word, 32-bit length flag
//
// Decode handshake: id_valid and every id_* output depend only on registered
// state. A transfer happens on a rising edge where id_valid && id_ready; while
// id_valid && !id_ready the head entry and all id_* outputs hold stable.
//
// BP_AW must not exceed BP_ADDR_W (the stored index width).
// ---------------------------------------------------------------------------
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned BP_AW = BP_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc_plus,
  input  logic             if_bp_taken,
  input  logic             if_bp_match,
  input  logic [BP_AW-1:0] if_bp_addr,
  input  logic [31:0]      if_bp_pc,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             fq_flush,
  output logic             fq_full,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus,
  output logic             id_bp_taken,
  output logic             id_bp_match,
  output logic [BP_AW-1:0] id_bp_addr,
  output logic [31:0]      id_bp_pc,
  output logic [31:0]      id_inst,
  output logic             id_is_ilen32
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] data_ok_q, data_ok_d;

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] resp_ptr_q,  resp_ptr_d;
  logic [PW-1:0] head_ptr_q,  head_ptr_d;

  // cnt: live entries. pend_cnt: entries allocated but still waiting for
  // their word (always the run resp_ptr..alloc_ptr). drop_cnt: responses
  // still owed to requests squashed by a flush.
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] flush_owed;

  logic fq_full_q, fq_full_d;

  logic alloc, fill, drop, pop;
  fq_entry_t head;

  // ------------------------------------------------------------------------
  // Event decode and next-state
  // ------------------------------------------------------------------------
  always_comb begin
    alloc = if_valid && !fq_full_q;
    pop   = id_valid && id_ready;
    drop  = imem_resp_valid && (drop_cnt_q != '0);
    // A response with nothing pending is a protocol error; never write it.
    fill  = imem_resp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0);

    alloc_ptr_d = alloc_ptr_q;
    resp_ptr_d  = resp_ptr_q;
    head_ptr_d  = head_ptr_q;
    cnt_d       = cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    data_ok_d   = data_ok_q;
    flush_owed  = drop_cnt_q + pend_cnt_q + CW'(alloc);

    if (fq_flush) begin
      // Everything still waiting for a word becomes a debt, including a
      // request handshaked this cycle. A response arriving this cycle is
      // always old, so it pays one unit of that debt.
      if (imem_resp_valid && (flush_owed != '0)) begin
        flush_owed = flush_owed - CW'(1);
      end
      alloc_ptr_d = '0;
      resp_ptr_d  = '0;
      head_ptr_d  = '0;
      cnt_d       = '0;
      pend_cnt_d  = '0;
      data_ok_d   = '0;
      drop_cnt_d  = flush_owed;
    end else begin
      if (alloc) begin
        data_ok_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d            = alloc_ptr_q + PW'(1);
      end
      if (fill) begin
        data_ok_d[resp_ptr_q] = 1'b1;
        resp_ptr_d            = resp_ptr_q + PW'(1);
      end
      if (pop) begin
        head_ptr_d = head_ptr_q + PW'(1);
      end
      if (drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      cnt_d      = cnt_q + CW'(alloc) - CW'(pop);
      pend_cnt_d = pend_cnt_q + CW'(alloc) - CW'(fill);
    end

    // Live entries plus owed responses never exceed DEPTH.
    fq_full_d = ({1'b0, cnt_d} + {1'b0, drop_cnt_d}) >= (CW + 1)'(DEPTH);
  end

  // ------------------------------------------------------------------------
  // Control registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      resp_ptr_q  <= '0;
      head_ptr_q  <= '0;
      cnt_q       <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      data_ok_q   <= '0;
      fq_full_q   <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      resp_ptr_q  <= resp_ptr_d;
      head_ptr_q  <= head_ptr_d;
      cnt_q       <= cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      data_ok_q   <= data_ok_d;
      fq_full_q   <= fq_full_d;
    end
  end

  // ------------------------------------------------------------------------
  // Entry storage. Metadata and the word land at different pointers, so the
  // fields are written separately. Entries are cleared on reset so the head
  // outputs read zero until the first instruction arrives.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!fq_flush) begin
      if (alloc) begin
        mem_q[alloc_ptr_q].pc       <= if_pc;
        mem_q[alloc_ptr_q].pc_plus  <= if_pc_plus;
        mem_q[alloc_ptr_q].bp_taken <= if_bp_taken;
        mem_q[alloc_ptr_q].bp_match <= if_bp_match;
        mem_q[alloc_ptr_q].bp_addr  <= BP_ADDR_W'(if_bp_addr);
        mem_q[alloc_ptr_q].bp_pc    <= if_bp_pc;
      end
      if (fill) begin
        mem_q[resp_ptr_q].inst <= imem_resp_data;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Head outputs: read straight from the registered entry (no bypass), so a
  // response shows up on id_valid exactly one cycle later.
  // ------------------------------------------------------------------------
  assign head         = mem_q[head_ptr_q];
  assign id_valid     = data_ok_q[head_ptr_q] && (cnt_q != '0);
  assign id_pc        = head.pc;
  assign id_pc_plus   = head.pc_plus;
  assign id_bp_taken  = head.bp_taken;
  assign id_bp_match  = head.bp_match;
  assign id_bp_addr   = BP_AW'(head.bp_addr);
  assign id_bp_pc     = head.bp_pc;
  assign id_inst      = head.inst;
  assign id_is_ilen32 = (head.inst[1:0] == 2'b11);
  assign fq_full      = fq_full_q;

  // ------------------------------------------------------------------------
  // Protocol checks
  // ------------------------------------------------------------------------
  a_no_req_when_full : assert property (@(posedge clk) disable iff (rst)
    !(if_valid && fq_full_q));

  a_resp_has_owner : assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((drop_cnt_q != '0) || (pend_cnt_q != '0)));

endmodule
